// File: rtl/perm_data_pipe.sv
// perm_data_pipe: pipelined priority selection over NSTAGE candidate words.
// Stage 0 always supplies the word; each later stage k overrides it when its
// select bit is set, so the highest set select wins. Slot k resolves stage k,
// with valid/ready backpressure and bubble collapsing through the pipe.
// Optional build macro PERM_DATA_PIPE_TAP_EN adds tap_dat/tap_vld, exposing the
// resolved word of the latest word set to leave each slot.
module perm_data_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned SW     = $clog2(NSTAGE)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NSTAGE*WIDTH-1:0] in_dat,
    input  logic [NSTAGE-1:0]       in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_dat,
    output logic [SW-1:0]           out_src,
    output logic                    busy
`ifdef PERM_DATA_PIPE_TAP_EN
    ,
    output logic [NSTAGE*WIDTH-1:0] tap_dat,
    output logic [NSTAGE-1:0]       tap_vld
`endif
);

    // Per-slot state: valid, running word, source index, carried candidates
    logic [NSTAGE-1:0]       v_q;
    logic [WIDTH-1:0]        d_q   [NSTAGE];
    logic [SW-1:0]           s_q   [NSTAGE];
    logic [NSTAGE*WIDTH-1:0] w_q   [NSTAGE];
    logic [NSTAGE-1:0]       sel_q [NSTAGE];

    logic [WIDTH-1:0]        d_nxt   [NSTAGE];
    logic [SW-1:0]           s_nxt   [NSTAGE];
    logic [NSTAGE*WIDTH-1:0] w_nxt   [NSTAGE];
    logic [NSTAGE-1:0]       sel_nxt [NSTAGE];

    logic [NSTAGE:0]   can_take;
    logic [NSTAGE-1:0] load;
    logic [NSTAGE-1:0] leave;

    // A slot can take when it, or any slot downstream of it, is empty, or the
    // consumer is accepting: the unrolled form of ~v_k | can_take_(k+1).
    assign can_take[NSTAGE] = out_ready;
    for (genvar k = 0; k < NSTAGE; k++) begin : g_flow
        assign can_take[k] = out_ready | ~(&v_q[NSTAGE-1:k]);
        assign leave[k]    = v_q[k] & can_take[k+1];
        if (k == 0) begin : g_head
            assign load[k] = in_valid & can_take[0];
        end else begin : g_body
            assign load[k] = v_q[k-1] & can_take[k];
        end
    end

    // Next contents of each slot: head from the input, others resolve stage k
    always_comb begin
        d_nxt[0]   = in_dat[WIDTH-1:0];
        s_nxt[0]   = '0;
        w_nxt[0]   = in_dat;
        sel_nxt[0] = in_sel;
        for (int k = 1; k < NSTAGE; k++) begin
            w_nxt[k]   = w_q[k-1];
            sel_nxt[k] = sel_q[k-1];
            if (sel_q[k-1][k]) begin
                d_nxt[k] = w_q[k-1][k*WIDTH +: WIDTH];
                s_nxt[k] = SW'(k);
            end else begin
                d_nxt[k] = d_q[k-1];
                s_nxt[k] = s_q[k-1];
            end
        end
    end

    // Slot registers; data only moves on a transfer into the slot
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                d_q[k]   <= '0;
                s_q[k]   <= '0;
                w_q[k]   <= '0;
                sel_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                v_q[k] <= load[k] | (v_q[k] & ~leave[k]);
                if (load[k]) begin
                    d_q[k]   <= d_nxt[k];
                    s_q[k]   <= s_nxt[k];
                    w_q[k]   <= w_nxt[k];
                    sel_q[k] <= sel_nxt[k];
                end
            end
        end
    end

    // The last slot's carried candidates have no further stage to feed
    logic unused_tail;
    assign unused_tail = ^{w_q[NSTAGE-1], sel_q[NSTAGE-1]};

`ifdef PERM_DATA_PIPE_TAP_EN
    // Capture each slot's resolved word as it leaves; pulse its valid once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tap_dat <= '0;
            tap_vld <= '0;
        end else begin
            tap_vld <= leave;
            for (int k = 0; k < NSTAGE; k++) begin
                if (leave[k]) begin
                    tap_dat[k*WIDTH +: WIDTH] <= d_q[k];
                end
            end
        end
    end
`endif

    assign in_ready  = can_take[0];
    assign out_valid = v_q[NSTAGE-1];
    assign out_dat   = d_q[NSTAGE-1];
    assign out_src   = s_q[NSTAGE-1];
    assign busy      = |v_q;

endmodule
